// File: rtl/core_multicycle.sv
// core_multicycle: multi-cycle RiSC-16 core (FETCH -> EXEC -> (MEM) -> WB)
// with req/ack instruction and data buses that tolerate wait states, an
// internal 8-entry register file and a halt instruction (JALR r0,r0,imm!=0).
// Optional feature macro: CORE_PERF_CNT_EN adds o_cycle_cnt / o_instret_cnt.
module core_multicycle #(
   parameter int                    p_WORD_LEN = 16,
   parameter int                    p_ADDR_LEN = 16,
   parameter logic [p_ADDR_LEN-1:0] p_RESET_PC = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  o_imem_req,
   output logic [p_ADDR_LEN-1:0] o_imem_addr,
   input  logic                  i_imem_ack,
   input  logic [15:0]           i_imem_data,
   output logic                  o_dmem_req,
   output logic                  o_dmem_we,
   output logic [p_ADDR_LEN-1:0] o_dmem_addr,
   output logic [p_WORD_LEN-1:0] o_dmem_wdata,
   input  logic                  i_dmem_ack,
   input  logic [p_WORD_LEN-1:0] i_dmem_rdata,
   output logic [p_ADDR_LEN-1:0] o_pc,
   output logic                  o_halted
`ifdef CORE_PERF_CNT_EN
   ,
   output logic [31:0]           o_cycle_cnt,
   output logic [31:0]           o_instret_cnt
`endif
);

   typedef logic [p_WORD_LEN-1:0] word_t;
   typedef logic [p_ADDR_LEN-1:0] addr_t;

   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   state_t state_q, state_d;
   addr_t  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   word_t  res_q, res_d;      // value written back in WB (ALU, load data or link)
   addr_t  npc_q, npc_d;      // PC to commit in WB
   addr_t  maddr_q, maddr_d;  // data bus address, held through MEM
   word_t  wdata_q, wdata_d;  // store data, held through MEM
   word_t  rf_q [8];

   logic imem_req, dmem_req, dmem_we, rf_we;

   // Instruction fields
   logic [2:0] op, ra, rb, rc;
   logic [6:0] imm7;
   logic [9:0] imm10;
   assign op    = ir_q[15:13];
   assign ra    = ir_q[12:10];
   assign rb    = ir_q[9:7];
   assign rc    = ir_q[2:0];
   assign imm7  = ir_q[6:0];
   assign imm10 = ir_q[9:0];

   word_t simm_w, ra_val, rb_val, rc_val, agu_sum;
   addr_t simm_a, pc_inc;
   logic  is_halt, is_wr;
   assign simm_w  = {{(p_WORD_LEN-7){imm7[6]}}, imm7};
   assign simm_a  = {{(p_ADDR_LEN-7){imm7[6]}}, imm7};
   // r0 is never written, so reading it always yields 0
   assign ra_val  = rf_q[ra];
   assign rb_val  = rf_q[rb];
   assign rc_val  = rf_q[rc];
   assign agu_sum = rb_val + simm_w;
   assign pc_inc  = pc_q + addr_t'(1);
   assign is_halt = (op == OP_JALR) && (ra == 3'd0) && (rb == 3'd0) && (imm7 != 7'd0);
   assign is_wr   = (op != OP_SW) && (op != OP_BEQ);

   // Next-state, datapath and bus control for the current FSM state
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      res_d    = res_q;
      npc_d    = npc_q;
      maddr_d  = maddr_q;
      wdata_d  = wdata_q;
      rf_we    = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (i_imem_ack) begin
               ir_d    = i_imem_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            npc_d   = pc_inc;
            state_d = S_WB;
            case (op)
               OP_ADD:  res_d = rb_val + rc_val;
               OP_ADDI: res_d = agu_sum;
               OP_NAND: res_d = ~(rb_val & rc_val);
               OP_LUI:  res_d = word_t'(imm10) << (p_WORD_LEN - 10);
               OP_SW: begin
                  maddr_d = addr_t'(agu_sum);
                  wdata_d = ra_val;
                  state_d = S_MEM;
               end
               OP_LW: begin
                  maddr_d = addr_t'(agu_sum);
                  state_d = S_MEM;
               end
               OP_BEQ: begin
                  if (ra_val == rb_val) npc_d = pc_inc + simm_a;
               end
               OP_JALR: begin
                  if (is_halt) begin
                     state_d = S_HALT;
                  end else begin
                     res_d = word_t'(pc_inc);
                     npc_d = addr_t'(rb_val);
                  end
               end
               default: ;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_SW);
            if (i_dmem_ack) begin
               if (op == OP_LW) res_d = i_dmem_rdata;
               state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we   = is_wr && (ra != 3'd0);
            pc_d    = npc_q;
            state_d = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   // State, PC, instruction, datapath and register-file registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_FETCH;
         pc_q    <= p_RESET_PC;
         ir_q    <= '0;
         res_q   <= '0;
         npc_q   <= '0;
         maddr_q <= '0;
         wdata_q <= '0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         res_q   <= res_d;
         npc_q   <= npc_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         if (rf_we) rf_q[ra] <= res_q;
      end
   end

   // Reset state is FETCH, so the fetch request is masked while reset is held
   assign o_imem_req   = imem_req & ~i_rst;
   assign o_imem_addr  = pc_q;
   assign o_dmem_req   = dmem_req;
   assign o_dmem_we    = dmem_we;
   assign o_dmem_addr  = maddr_q;
   assign o_dmem_wdata = wdata_q;
   assign o_pc         = pc_q;
   assign o_halted     = (state_q == S_HALT);

`ifdef CORE_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instret_cnt_q;

   // Cycle counter (frozen in HALT) and retired-instruction counter (WB cycles)
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         if (state_q != S_HALT) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (state_q == S_WB) instret_cnt_q <= instret_cnt_q + 32'd1;
      end
   end

   assign o_cycle_cnt   = cycle_cnt_q;
   assign o_instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_core_multicycle.sv
// tb_core_multicycle: directed programs for core_multicycle with a 16-bit and
// a 32-bit instance, bus responders with programmable ack wait states.
module tb_core_multicycle;

   localparam int OP_ADD = 0, OP_ADDI = 1, OP_NAND = 2, OP_LUI = 3;
   localparam int OP_SW = 4, OP_LW = 5, OP_BEQ = 6, OP_JALR = 7;
   localparam logic [15:0] HALT = 16'hE001;  // JALR r0,r0,1

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 16-bit instance
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
   logic [15:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata, pc;
   // 32-bit instance
   logic        i32_req, i32_ack, d32_req, d32_we, d32_ack, halted32;
   logic [15:0] i32_addr, i32_data, d32_addr, pc32;
   logic [31:0] d32_wdata, d32_rdata;
`ifdef CORE_PERF_CNT_EN
   logic [31:0] cyc_cnt, instret_cnt, cyc_cnt32, instret_cnt32;
`endif

   core_multicycle u_dut (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .i_imem_data(imem_data),
      .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
      .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata), .o_pc(pc), .o_halted(halted)
`ifdef CORE_PERF_CNT_EN
      , .o_cycle_cnt(cyc_cnt), .o_instret_cnt(instret_cnt)
`endif
   );

   core_multicycle #(.p_WORD_LEN(32)) u_dut32 (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(i32_req), .o_imem_addr(i32_addr), .i_imem_ack(i32_ack), .i_imem_data(i32_data),
      .o_dmem_req(d32_req), .o_dmem_we(d32_we), .o_dmem_addr(d32_addr), .o_dmem_wdata(d32_wdata),
      .i_dmem_ack(d32_ack), .i_dmem_rdata(d32_rdata), .o_pc(pc32), .o_halted(halted32)
`ifdef CORE_PERF_CNT_EN
      , .o_cycle_cnt(cyc_cnt32), .o_instret_cnt(instret_cnt32)
`endif
   );

   logic [15:0] imem [64];
   logic [15:0] dmem [256];
   logic [31:0] dmem32 [256];

   int n_vec = 0, n_bad = 0;
   int cyc = 0;
   int imem_wait = 0, dmem_wait = 0;
   int iw_cnt = 0, dw_cnt = 0, unstable = 0;
   logic prev_ireq = 1'b0, prev_dreq = 1'b0, force_dack = 1'b0;
   logic [15:0] cap_addr, cap_wd;
   logic cap_we;
   int fstart_cyc[$];
   logic [15:0] fstart_pc[$];
   logic [15:0] st_addr[$];
   logic [15:0] st_data[$];

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rrr(input int op, input int a, input int b, input int c);
      return {op[2:0], a[2:0], b[2:0], 4'b0000, c[2:0]};
   endfunction
   function automatic logic [15:0] rri(input int op, input int a, input int b, input int imm);
      return {op[2:0], a[2:0], b[2:0], imm[6:0]};
   endfunction
   function automatic logic [15:0] ri(input int op, input int a, input int imm);
      return {op[2:0], a[2:0], imm[9:0]};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // 16-bit instance bus responders; log fetch starts and stores
   initial begin
      imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (imem_req && !rst) begin
            if (!prev_ireq) begin
               fstart_cyc.push_back(cyc);
               fstart_pc.push_back(pc);
            end
            if (iw_cnt >= imem_wait) begin
               imem_ack = 1'b1;
               imem_data = imem[imem_addr[5:0]];
            end else begin
               imem_ack = 1'b0;
               iw_cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            iw_cnt = 0;
         end
         prev_ireq = imem_req && !rst;

         if (force_dack) begin
            dmem_ack = 1'b1;
            force_dack = 1'b0;
         end else if (dmem_req && !rst) begin
            if (!prev_dreq) begin
               cap_addr = dmem_addr; cap_wd = dmem_wdata; cap_we = dmem_we;
            end else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wd || dmem_we !== cap_we) begin
               unstable++;
            end
            if (dw_cnt >= dmem_wait) begin
               dmem_ack = 1'b1;
               dw_cnt = 0;
               if (dmem_we) begin
                  dmem[dmem_addr[7:0]] = dmem_wdata;
                  st_addr.push_back(dmem_addr);
                  st_data.push_back(dmem_wdata);
               end else begin
                  dmem_rdata = dmem[dmem_addr[7:0]];
               end
            end else begin
               dmem_ack = 1'b0;
               dw_cnt++;
            end
         end else begin
            dmem_ack = 1'b0;
            dw_cnt = 0;
         end
         prev_dreq = dmem_req && !rst;
      end
   end

   // 32-bit instance: zero-wait buses sharing the same program
   initial begin
      i32_ack = 1'b0; i32_data = '0; d32_ack = 1'b0; d32_rdata = '0;
      forever begin
         @(negedge clk);
         i32_ack = i32_req && !rst;
         if (i32_req && !rst) i32_data = imem[i32_addr[5:0]];
         d32_ack = d32_req && !rst;
         if (d32_req && !rst) begin
            if (d32_we) dmem32[d32_addr[7:0]] = d32_wdata;
            else d32_rdata = dmem32[d32_addr[7:0]];
         end
      end
   end

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = HALT;
   endtask

   task automatic clear_logs();
      fstart_cyc.delete(); fstart_pc.delete(); st_addr.delete(); st_data.delete();
      unstable = 0;
   endtask

   task automatic apply_reset(input string tag, input int iw, input int dw);
      @(posedge clk);
      #2 rst = 1'b1;
      imem_wait = iw;
      dmem_wait = dw;
      #1;
      check_vec({tag, "_rst_ireq"}, 32'(imem_req), 32'd0);
      check_vec({tag, "_rst_dreq"}, 32'(dmem_req), 32'd0);
      check_vec({tag, "_rst_we"}, 32'(dmem_we), 32'd0);
      check_vec({tag, "_rst_daddr"}, 32'(dmem_addr), 32'd0);
      check_vec({tag, "_rst_wdata"}, 32'(dmem_wdata), 32'd0);
      check_vec({tag, "_rst_halted"}, 32'(halted), 32'd0);
      check_vec({tag, "_rst_pc"}, 32'(pc), 32'd0);
      clear_logs();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1 check_vec({tag, "_rel_ireq"}, 32'(imem_req), 32'd1);
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_vec(tag, 32'(halted), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int reqs, bad_loop, n;
      rst = 1'b0;

      // A: ADDI/ADDI/ADD, store result, halt
      clear_imem();
      imem[0] = rri(OP_ADDI, 1, 0, 5);
      imem[1] = rri(OP_ADDI, 2, 0, -3);
      imem[2] = rrr(OP_ADD, 3, 1, 2);
      imem[3] = rri(OP_SW, 3, 0, 0);
      apply_reset("A", 0, 0);
      wait_halt("A_halt", 200);
      check_vec("A_st_data", 32'(st_data[0]), 32'd2);
      check_vec("A_st_addr", 32'(st_addr[0]), 32'd0);
      check_vec("A_lat_addi", 32'(fstart_cyc[1] - fstart_cyc[0]), 32'd3);
      check_vec("A_lat_addi2", 32'(fstart_cyc[2] - fstart_cyc[1]), 32'd3);
      check_vec("A_lat_add", 32'(fstart_cyc[3] - fstart_cyc[2]), 32'd3);
      check_vec("A_lat_sw", 32'(fstart_cyc[4] - fstart_cyc[3]), 32'd4);
      check_vec("A_pc3", 32'(fstart_pc[3]), 32'd3);
      check_vec("A_halt_pc", 32'(pc), 32'd4);
      reqs = 0;
      repeat (10) begin
         @(negedge clk);
         if (imem_req || dmem_req) reqs++;
      end
      check_vec("A_noreq_halted", 32'(reqs), 32'd0);
      check_vec("A_still_halted", 32'(halted), 32'd1);
`ifdef CORE_PERF_CNT_EN
      check_vec("A_instret", instret_cnt, 32'd4);
      check_vec("A_cycles", cyc_cnt, 32'd15);
`endif

      // B: LUI on both widths, r0 write discarded, NAND
      clear_imem();
      imem[0] = ri(OP_LUI, 1, 10'h3FF);
      imem[1] = rri(OP_SW, 1, 0, 1);
      imem[2] = rri(OP_ADDI, 0, 0, 7);
      imem[3] = rrr(OP_ADD, 5, 0, 0);
      imem[4] = rri(OP_SW, 5, 0, 2);
      imem[5] = rrr(OP_NAND, 6, 1, 1);
      imem[6] = rri(OP_SW, 6, 0, 3);
      apply_reset("B", 0, 0);
      wait_halt("B_halt", 300);
      n = 0;
      while (!halted32 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_vec("B_halt32", 32'(halted32), 32'd1);
      check_vec("B_lui16", 32'(st_data[0]), 32'h0000FFC0);
      check_vec("B_r0_zero", 32'(st_data[1]), 32'd0);
      check_vec("B_nand16", 32'(st_data[2]), 32'h0000003F);
      check_vec("B_nand_addr", 32'(st_addr[2]), 32'd3);
      check_vec("B_lui32", dmem32[1], 32'hFFC00000);
      check_vec("B_nand32", dmem32[3], 32'h003FFFFF);

      // C: SW then LW with two data wait states each
      clear_imem();
      imem[0] = rri(OP_ADDI, 1, 0, -7);
      imem[1] = rri(OP_SW, 1, 0, 10);
      imem[2] = rri(OP_LW, 4, 0, 10);
      imem[3] = rri(OP_SW, 4, 0, 11);
      dmem[10] = 16'h0000;
      apply_reset("C", 0, 2);
      wait_halt("C_halt", 300);
      check_vec("C_nstores", 32'(st_addr.size()), 32'd2);
      check_vec("C_sw_addr", 32'(st_addr[0]), 32'd10);
      check_vec("C_sw_data", 32'(st_data[0]), 32'h0000FFF9);
      check_vec("C_lw_data", 32'(st_data[1]), 32'h0000FFF9);
      check_vec("C_lw_addr2", 32'(st_addr[1]), 32'd11);
      check_vec("C_lat_sw", 32'(fstart_cyc[2] - fstart_cyc[1]), 32'd6);
      check_vec("C_lat_lw", 32'(fstart_cyc[3] - fstart_cyc[2]), 32'd6);
      check_vec("C_stable", 32'(unstable), 32'd0);

      // D1: BEQ r0,r0,-1 at PC 4 loops forever, one fetch wait state
      clear_imem();
      imem[0] = rri(OP_ADDI, 2, 0, 32);
      imem[1] = rri(OP_ADDI, 3, 0, 1);
      imem[2] = rri(OP_ADDI, 3, 0, 1);
      imem[3] = rri(OP_ADDI, 3, 0, 1);
      imem[4] = rri(OP_BEQ, 0, 0, -1);
      apply_reset("D1", 1, 0);
      repeat (60) @(negedge clk);
      check_vec("D1_not_halted", 32'(halted), 32'd0);
      check_vec("D1_pc", 32'(pc), 32'd4);
      check_vec("D1_nfetch", 32'(fstart_pc.size() >= 10), 32'd1);
      bad_loop = 0;
      for (int j = 4; j < fstart_pc.size(); j++) if (fstart_pc[j] != 16'd4) bad_loop++;
      check_vec("D1_loop_pcs", 32'(bad_loop), 32'd0);
      check_vec("D1_lat_addi", 32'(fstart_cyc[1] - fstart_cyc[0]), 32'd4);
      check_vec("D1_lat_beq", 32'(fstart_cyc[6] - fstart_cyc[5]), 32'd4);

      // D2: BEQ not taken / taken, JALR link and jump, JALR with A == B
      clear_imem();
      imem[0]  = rri(OP_ADDI, 2, 0, 32);
      imem[1]  = rri(OP_ADDI, 1, 0, 1);
      imem[2]  = rri(OP_BEQ, 1, 0, 5);
      imem[3]  = rri(OP_BEQ, 1, 1, 4);
      imem[8]  = rri(OP_ADDI, 3, 0, 9);
      imem[9]  = rri(OP_JALR, 7, 2, 0);
      imem[32] = rri(OP_SW, 7, 0, 5);
      imem[33] = rri(OP_ADDI, 4, 0, 36);
      imem[34] = rri(OP_JALR, 4, 4, 0);
      imem[36] = rri(OP_SW, 4, 0, 6);
      apply_reset("D2", 0, 0);
      wait_halt("D2_halt", 300);
      check_vec("D2_beq_nt", 32'(fstart_pc[3]), 32'd3);
      check_vec("D2_beq_t", 32'(fstart_pc[4]), 32'd8);
      check_vec("D2_jalr_pc", 32'(fstart_pc[6]), 32'h20);
      check_vec("D2_jalr_link", 32'(st_data[0]), 32'd10);
      check_vec("D2_jalr_ab_pc", 32'(fstart_pc[9]), 32'd36);
      check_vec("D2_jalr_ab_link", 32'(st_data[1]), 32'd35);
      check_vec("D2_halt_pc", 32'(pc), 32'd37);
      check_vec("D2_lat_jalr", 32'(fstart_cyc[6] - fstart_cyc[5]), 32'd3);

      // E: reset while a store is waiting for its ack
      clear_imem();
      imem[0] = rri(OP_ADDI, 1, 0, 9);
      imem[1] = rri(OP_SW, 1, 0, 3);
      apply_reset("E", 0, 3);
      n = 0;
      while (!dmem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_vec("E_dreq_seen", 32'(dmem_req), 32'd1);
      #1 rst = 1'b1;
      force_dack = 1'b1;
      #1;
      check_vec("E_dreq_drop", 32'(dmem_req), 32'd0);
      check_vec("E_we_drop", 32'(dmem_we), 32'd0);
      check_vec("E_wdata_clr", 32'(dmem_wdata), 32'd0);
      check_vec("E_pc_reset", 32'(pc), 32'd0);
      clear_logs();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_vec("E_refetch_req", 32'(imem_req), 32'd1);
      check_vec("E_refetch_addr", 32'(imem_addr), 32'd0);
      wait_halt("E_halt", 300);
      check_vec("E_nstores", 32'(st_addr.size()), 32'd1);
      check_vec("E_st_data", 32'(st_data[0]), 32'd9);
      check_vec("E_halt_pc", 32'(pc), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/core_multicycle.md
Name: core_multicycle

Overview:
Parametrised multi-cycle successor of the single-cycle RiSC-16 core.
- Executes the same 8-opcode ISA over an FSM: FETCH -> EXEC -> (MEM) -> WB.
- Talks to external instruction and data memories through req/ack handshakes that tolerate wait states.
- Data width and bus address width are generalised; the register file is internal; a halt instruction is added.

Parameters:
- p_WORD_LEN, 16, datapath/register width; legal range 16..32.
- p_ADDR_LEN, 16, address width of both memory buses; PC width.
- p_RESET_PC, 0, PC value loaded on reset.

Ports:
- i_clk  in  1  main clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- o_imem_req  out  1  instruction fetch request.
- o_imem_addr  out  p_ADDR_LEN  fetch address (= PC).
- i_imem_ack  in  1  fetch data valid this cycle.
- i_imem_data  in  16  instruction word.
- o_dmem_req  out  1  data access request.
- o_dmem_we  out  1  1 = store, 0 = load; valid while o_dmem_req is high.
- o_dmem_addr  out  p_ADDR_LEN  data address.
- o_dmem_wdata  out  p_WORD_LEN  store data.
- i_dmem_ack  in  1  access complete; load data valid this cycle.
- i_dmem_rdata  in  p_WORD_LEN  load data.
- o_pc  out  p_ADDR_LEN  current PC.
- o_halted  out  1  core stopped on a halt instruction.

Behaviour:
Reset (asynchronous, immediate):
- state = FETCH; PC = p_RESET_PC; IR = 0; r0..r7 = 0.
- All req/we outputs = 0; o_dmem_addr/o_dmem_wdata = 0; o_halted = 0.
- Reset mid-transaction drops req at once; a later ack is ignored.
- After release, the first FETCH request issues in the first cycle.

Register file:
- r0 always reads 0; writes to r0 are discarded.

Instruction fields:
- op = [15:13], A = [12:10], B = [9:7], C = [2:0].
- imm7 = [6:0], sign-extended to p_WORD_LEN / p_ADDR_LEN.
- imm10 = [9:0].

FETCH:
- o_imem_req = 1, o_imem_addr = PC.
- Wait while !i_imem_ack.
- On ack: latch IR = i_imem_data and go to EXEC. Ack in the first req cycle is legal.

EXEC (1 cycle):
- Read operands, compute result, branch target and memory address into internal registers.
- LW/SW go to MEM; all other ops go to WB.

Operation semantics (arithmetic modulo 2^p_WORD_LEN):
- ADD: rA = rB + rC.
- ADDI: rA = rB + simm7.
- NAND: rA = ~(rB & rC).
- LUI: rA = imm10 << (p_WORD_LEN-10), low bits zero.
- LW: rA = mem[rB + simm7].
- SW: mem[rB + simm7] = rA.
- BEQ: if rA == rB, PC = PC + 1 + simm7.
- JALR: rA = PC + 1; PC = rB.
- Halt: JALR with A = 0, B = 0 and imm7 != 0. Enters HALT; PC unchanged.
- Address = low p_ADDR_LEN bits of the sum. PC arithmetic wraps modulo 2^p_ADDR_LEN.

MEM:
- o_dmem_req = 1; addr/wdata/we held stable until ack.
- On ack: a load captures i_dmem_rdata; go to WB.

WB (1 cycle):
- Register write (if any) and PC update (PC + 1 or branch/jump target); go to FETCH.
- JALR with A == B: the link value is written and PC = old rB (operand read in EXEC).

HALT:
- Terminal state; o_halted = 1; no requests issue.
- Left only by reset.

Latency with zero-wait memory:
- 3 cycles for ALU ops, BEQ and JALR.
- 4 cycles for LW/SW.
- Each wait cycle of ack adds 1.

Handshake:
- An ack while the corresponding req is low is ignored.
- The two buses are never requested in the same cycle.

Optional Feature:
CORE_PERF_CNT_EN
- Defined: adds outputs o_cycle_cnt (32 bits) and o_instret_cnt (32 bits), both reset to 0.
  - o_cycle_cnt increments every cycle except in HALT.
  - o_instret_cnt increments in each WB cycle.
  - Both wrap at 2^32.
- Undefined: neither port nor the counter logic exists.

Test Plan:
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2, zero-wait buses -> r3 = 2; each instruction takes 3 cycles; PC = 3.
- LUI r1,0x3FF with p_WORD_LEN=16 -> r1 = 0xFFC0. Same program with p_WORD_LEN=32 -> r1 = 0xFFC00000.
- SW r1,r0,10 then LW r4,r0,10, i_dmem_ack delayed 2 cycles each -> addr/wdata/we held stable throughout; r4 = r1; each access instruction takes 6 cycles.
- BEQ r0,r0,-1 at PC 4 -> PC = 4 (loops). JALR r7,r2 with r2 = 0x20 at PC 9 -> r7 = 10, PC = 0x20.
- ADDI r0,r0,7 then ADD r1,r0,r0 -> r1 = 0 (r0 write discarded). JALR r0,r0 with imm 1 -> o_halted = 1, no further requests.
- Assert i_rst while o_dmem_req is high, with i_dmem_ack arriving the next cycle -> req drops in the same cycle; ack is ignored; PC = p_RESET_PC; fetch restarts after release.
